// File: rtl/act_pack_serial.sv
// Requantizes signed sums to 4-bit sign-magnitude nibbles and packs LANES of them into a ping-pong buffered word.
// Build option: ACT_PACK_RELU_EN zeroes negative activations before packing.
module act_pack_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic       clr,
  input  logic       wr_sel,
  input  logic       rd_sel,
  input  logic [3:0] nib,
  output logic [3:0] nib_out
);
  logic [1:0][3:0] nib_d, nib_q;

  always_comb begin
    nib_d = nib_q;
    if (we)       nib_d[wr_sel] = nib;
    else if (clr) nib_d[wr_sel] = 4'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) nib_q <= '0;
    else     nib_q <= nib_d;
  end

  assign nib_out = nib_q[rd_sel];
endmodule

module act_pack_serial #(
  parameter int SUM_W = 16,
  parameter int LANES = 32,
  parameter int SHIFT = 4,
  localparam int CNT_W = $clog2(LANES) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SUM_W-1:0]   sum_in,
  input  logic               sum_valid,
  output logic               sum_ready,
  input  logic               flush,
  output logic [4*LANES-1:0] act_out,
  output logic               act_valid,
  input  logic               act_ready,
  output logic [CNT_W-1:0]   lane_cnt
);
  logic [SUM_W:0]     mag_abs, mag_sh;
  logic [2:0]         mag_sat;
  logic               sgn;
  logic [3:0]         nib_new;

  logic [1:0]         full_d, full_q;
  logic               wr_ptr_d, wr_ptr_q;
  logic               rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0]   lane_cnt_d, lane_cnt_q;
  logic               acc_fire, rel_fire, close_fire;

  // Magnitude is one bit wider so the most negative sum does not wrap.
  always_comb begin
    sgn     = sum_in[SUM_W-1];
    mag_abs = sgn ? (~{sgn, sum_in} + (SUM_W+1)'(1)) : {1'b0, sum_in};
    mag_sh  = mag_abs >> SHIFT;
    mag_sat = (mag_sh > (SUM_W+1)'(7)) ? 3'd7 : mag_sh[2:0];
    nib_new = (mag_sat == 3'd0) ? 4'b0 : {sgn, mag_sat};
`ifdef ACT_PACK_RELU_EN
    if (sgn) nib_new = 4'b0;
`endif
  end

  assign sum_ready = ~(full_q[0] & full_q[1]);
  assign act_valid = full_q[rd_ptr_q];
  assign lane_cnt  = lane_cnt_q;

  always_comb begin
    acc_fire   = sum_valid & sum_ready;
    rel_fire   = act_valid & act_ready;
    close_fire = (acc_fire && lane_cnt_q == CNT_W'(LANES-1)) ||
                 (flush && (lane_cnt_q != '0 || acc_fire));
    full_d     = full_q;
    if (rel_fire)   full_d[rd_ptr_q] = 1'b0;
    if (close_fire) full_d[wr_ptr_q] = 1'b1;
    wr_ptr_d   = close_fire ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d   = rel_fire   ? ~rd_ptr_q : rd_ptr_q;
    lane_cnt_d = lane_cnt_q;
    if (close_fire)    lane_cnt_d = '0;
    else if (acc_fire) lane_cnt_d = lane_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      lane_cnt_q <= '0;
    end else begin
      full_q     <= full_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      lane_cnt_q <= lane_cnt_d;
    end
  end

  // Writing lane 0 wipes the rest of the fill buffer, so a flushed word is zero-padded.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_pack_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .we      (acc_fire && lane_cnt_q == CNT_W'(i)),
      .clr     (acc_fire && lane_cnt_q == '0 && i != 0),
      .wr_sel  (wr_ptr_q),
      .rd_sel  (rd_ptr_q),
      .nib     (nib_new),
      .nib_out (act_out[4*i +: 4])
    );
  end
endmodule

// File: tb/tb_act_pack_serial.sv
// Self-checking bench for act_pack_serial: requant table, directed corner sequences, randomized run against a queue model.
module tb_act_pack_serial;
  localparam int SHIFT = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  sum_in = '0;
  logic         sum_valid = 1'b0;
  logic         sum_ready;
  logic         flush = 1'b0;
  logic [127:0] act_out;
  logic         act_valid;
  logic         act_ready = 1'b0;
  logic [5:0]   lane_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [127:0] mq[$];
  logic [127:0] mcur = '0;
  int           mcnt = 0;

  typedef struct {
    logic [15:0] sum;
    logic [3:0]  nib;
  } vec_t;
  vec_t tbl[14];

  act_pack_serial dut (
    .clk(clk), .rst(rst), .sum_in(sum_in), .sum_valid(sum_valid),
    .sum_ready(sum_ready), .flush(flush), .act_out(act_out),
    .act_valid(act_valid), .act_ready(act_ready), .lane_cnt(lane_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_nib(input logic [15:0] s);
    int v, m;
    v = int'($signed(s));
    m = (v < 0) ? -v : v;
    m = m / (1 << SHIFT);
    if (m > 7) m = 7;
    if (m == 0) return 4'h0;
`ifdef ACT_PACK_RELU_EN
    if (v < 0) return 4'h0;
`endif
    return {(v < 0), m[2:0]};
  endfunction

  function automatic logic [3:0] relu_adj(input logic [3:0] n);
`ifdef ACT_PACK_RELU_EN
    if (n[3]) return 4'h0;
`endif
    return n;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic v, input logic [15:0] s,
                              input logic f, input logic a);
    logic ready, acc, rel;
    if (r) begin
      mq.delete();
      mcur = '0;
      mcnt = 0;
      return;
    end
    ready = (mq.size() < 2);
    acc   = v && ready;
    rel   = (mq.size() > 0) && a;
    if (rel) void'(mq.pop_front());
    if (acc) begin
      mcur[4*mcnt +: 4] = ref_nib(s);
      mcnt++;
    end
    if (mcnt == 32 || (f && mcnt > 0)) begin
      mq.push_back(mcur);
      mcur = '0;
      mcnt = 0;
    end
  endtask

  task automatic check_model();
    chk("lane_cnt", 128'(lane_cnt), 128'(mcnt));
    chk("act_valid", 128'(act_valid), 128'(mq.size() > 0));
    chk("sum_ready", 128'(sum_ready), 128'(mq.size() < 2));
    if (mq.size() > 0) chk("act_out", act_out, mq[0]);
  endtask

  task automatic step(input logic r, input logic v, input logic [15:0] s,
                      input logic f, input logic a);
    rst = r; sum_valid = v; sum_in = s; flush = f; act_ready = a;
    @(posedge clk);
    model_update(r, v, s, f, a);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    logic [127:0] ones;
    logic [19:0]  exp20;
    int           tmp;
    logic [15:0]  s;
    logic [15:0]  bnd[9];

    tbl[0]  = '{16'd53,     4'h3};
    tbl[1]  = '{-16'sd53,   4'hB};
    tbl[2]  = '{16'd200,    4'h7};
    tbl[3]  = '{-16'sd5,    4'h0};
    tbl[4]  = '{16'h8000,   4'hF};
    tbl[5]  = '{16'd0,      4'h0};
    tbl[6]  = '{16'd15,     4'h0};
    tbl[7]  = '{16'd16,     4'h1};
    tbl[8]  = '{-16'sd16,   4'h9};
    tbl[9]  = '{16'd127,    4'h7};
    tbl[10] = '{16'd112,    4'h7};
    tbl[11] = '{16'd111,    4'h6};
    tbl[12] = '{16'h7FFF,   4'h7};
    tbl[13] = '{-16'sd17,   4'h9};

    bnd[0] = 16'h8000; bnd[1] = 16'h7FFF; bnd[2] = 16'h0000;
    bnd[3] = 16'hFFFF; bnd[4] = 16'd15;   bnd[5] = 16'd16;
    bnd[6] = 16'hFFF0; bnd[7] = 16'd127;  bnd[8] = 16'd128;

    // reset for two cycles
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_act_out", act_out, '0);
    chk("rst_act_valid", 128'(act_valid), 128'(0));
    chk("rst_sum_ready", 128'(sum_ready), 128'(1));
    chk("rst_lane_cnt", 128'(lane_cnt), 128'(0));

    // single-lane words from the requant table
    for (int i = 0; i < 14; i++) begin
      step(0, 1, tbl[i].sum, 1, 0);
      chk("tbl_word", act_out, {124'b0, relu_adj(tbl[i].nib)});
      chk("tbl_valid", 128'(act_valid), 128'(1));
      step(0, 0, 0, 0, 1);
    end

    // five sums then a standalone flush
    step(0, 1, 16'd53, 0, 0);
    step(0, 1, -16'sd53, 0, 0);
    step(0, 1, 16'd200, 0, 0);
    step(0, 1, -16'sd5, 0, 0);
    step(0, 1, 16'h8000, 0, 0);
    step(0, 0, 0, 1, 0);
`ifdef ACT_PACK_RELU_EN
    exp20 = 20'h00703;
`else
    exp20 = 20'hF07B3;
`endif
    chk("seq5_valid", 128'(act_valid), 128'(1));
    chk("seq5_low", 128'(act_out[19:0]), 128'(exp20));
    chk("seq5_high", 128'(act_out[127:20]), '0);
    step(0, 0, 0, 0, 1);

    // full word of 16s with consumer ready
    for (int k = 0; k < 32; k++) step(0, 1, 16'd16, 0, 1);
    for (int k = 0; k < 32; k++) ones[4*k +: 4] = 4'h1;
    chk("full_valid", 128'(act_valid), 128'(1));
    chk("full_word", act_out, ones);
    step(0, 0, 0, 0, 1);
    chk("full_released", 128'(act_valid), 128'(0));

    // back-pressure: two words buffered, 65th held
    for (int k = 0; k < 64; k++) step(0, 1, 16'd32, 0, 0);
    chk("bp_ready_low", 128'(sum_ready), 128'(0));
    step(0, 1, 16'd48, 0, 0);
    step(0, 1, 16'd48, 0, 0);
    chk("bp_held_cnt", 128'(lane_cnt), 128'(0));
    step(0, 1, 16'd48, 0, 1);
    chk("bp_no_fallthru", 128'(lane_cnt), 128'(0));
    chk("bp_ready_back", 128'(sum_ready), 128'(1));
    step(0, 1, 16'd48, 0, 0);
    chk("bp_lane0_cnt", 128'(lane_cnt), 128'(1));
    // close and release on the same edge
    step(0, 0, 0, 1, 1);
    chk("bp_lane0_word", act_out, 128'h3);
    step(0, 0, 0, 0, 1);
    chk("bp_drained", 128'(act_valid), 128'(0));

    // flush with empty fill buffer
    step(0, 0, 0, 1, 0);
    chk("flush_noop_valid", 128'(act_valid), 128'(0));
    chk("flush_noop_cnt", 128'(lane_cnt), 128'(0));

    // reset mid-fill
    for (int k = 0; k < 10; k++) step(0, 1, 16'd100, 0, 0);
    chk("mid_cnt", 128'(lane_cnt), 128'(10));
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("mid_rst_cnt", 128'(lane_cnt), 128'(0));
    chk("mid_rst_valid", 128'(act_valid), 128'(0));
    chk("mid_rst_out", act_out, '0);
    step(0, 1, 16'd16, 1, 0);
    chk("mid_next_word", act_out, 128'h1);
    step(0, 0, 0, 0, 1);

    // randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: s = 16'($urandom);
        1: begin tmp = int'($urandom_range(0, 300)) - 150; s = tmp[15:0]; end
        2: s = bnd[$urandom_range(0, 8)];
        default: begin tmp = int'($urandom_range(0, 2000)) - 1000; s = tmp[15:0]; end
      endcase
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, s,
           $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/act_pack_serial.md
Name: act_pack_serial

Overview:
- Writer side of the bit-serial dot-product datapath.
- Collects signed 16-bit dot-product sums from the counting array one at a time and requantizes each to a 4-bit sign-magnitude activation.
- Packs 32 activations into the 128-bit activation word the bit-serial counters consume.
- Double-buffers so packing of the next word overlaps consumption of the current one.

Parameters:
- SUM_W, 16, width of incoming signed sum.
- LANES, 32, activations per packed word (word width = 4*LANES).
- SHIFT, 4, right-shift applied to |sum| before saturation.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- sum_in  in  SUM_W  signed sum, two's complement.
- sum_valid  in  1  sum_in valid.
- sum_ready  out  1  block can accept sum_in this cycle.
- flush  in  1  close the partial word, zero-padding the unfilled lanes.
- act_out  out  4*LANES  packed activation word.
- act_valid  out  1  act_out holds a complete word.
- act_ready  in  1  consumer takes act_out this cycle.
- lane_cnt  out  log2(LANES)+1  lanes filled in the current fill buffer (debug).

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. While rst=1 at a clk edge:
  - act_out=0, act_valid=0, sum_ready=1, lane_cnt=0.
  - Both buffers are marked empty and the fill pointer selects buffer 0.
  - Reset mid-fill or while a word is pending discards all data; no partial word is emitted.
- Lane format: lane i occupies act_out[4i+3:4i].
  - Bit 4i+3 is the sign (1 = negative).
  - Bits 4i+2..4i are the magnitude, MSB at 4i+2.
  - Lane 0 is the first sum accepted into a word.
- Requantization, combinational on sum_in:
  - mag = |sum_in| computed in SUM_W+1 bits, so -32768 gives 32768.
  - mag = mag >> SHIFT, then saturate to 7.
  - sign = sum_in[SUM_W-1].
  - If the post-saturation mag is 0, the nibble is 0000 (no negative zero).
- Accept: a sum is accepted when sum_valid && sum_ready at a rising edge. The nibble is written into lane lane_cnt of the fill buffer and lane_cnt increments.
- Word close:
  - Trigger: the 32nd lane is accepted, or flush=1 with lane_cnt>0.
  - Effect: the fill buffer is marked full, the fill pointer toggles, and lane_cnt returns to 0.
- Flush details:
  - Flush with lane_cnt=0 and no sum accepted in that cycle is a no-op.
  - Flush in the same cycle as an accepted sum: the sum is written first, then the word closes. The word includes that lane; lanes above it are 0000.
- Buffers: 2-entry ping-pong; read pointer is independent of the fill pointer.
  - act_out always drives the read buffer.
  - act_valid = read buffer full.
  - On act_valid && act_ready the read buffer is marked empty and the read pointer toggles.
  - act_out holds stable while act_valid=1 and act_ready=0. The consumer may sample it over its 3-cycle bit-serial window before asserting act_ready.
- Back-pressure: sum_ready = 0 when both buffers are full.
  - In the cycle a buffer is released by act_ready, sum_ready is still evaluated from the registered flags. Fall-through is not permitted, so sum_ready rises one cycle later.
- Latency: the word closes at edge N and act_valid=1 from edge N (registered flag) if the read buffer was empty. The nibble is visible on act_out in cycle N+0 after that edge.
- Throughput: one sum per cycle sustained while act_ready keeps pace. A word closes every 32 cycles.
- Simultaneous close and release: if a word closes while the other buffer is released in the same edge, both state updates take effect. No data is lost.

Optional Feature:
- Macro: ACT_PACK_RELU_EN.
- Defined: negative sums (sign bit 1) map to nibble 0000 before packing, so the sign bit in act_out is always 0. Positive path is unchanged.
- Undefined: signed sign-magnitude packing exactly as above.

Test Plan:
- rst=1 for 2 cycles, then release -> act_out=0, act_valid=0, sum_ready=1, lane_cnt=0.
- SHIFT=4; sums 53, -53, 200, -5, -32768 in lanes 0-4, then flush -> act_valid=1 and act_out[19:0]=0xF07B3 (lanes: 0011, 1011, 0111, 0000, 1111); remaining bits 0.
- 32 sums of value 16 with act_ready=1 -> act_valid rises at the edge of the 32nd accept; act_out=0x1111...1 (32 nibbles of 0001); released next cycle.
- act_ready=0; send 64 sums of 32 followed by a 65th -> two words buffered, sum_ready=0 from the 64th accept, the 65th is held. Then act_ready=1 for 1 cycle -> sum_ready returns 1 cycle later and the 65th lands in lane 0.
- flush asserted with lane_cnt=0 and sum_valid=0 -> no state change, act_valid stays 0.
- Assert rst after 10 accepted sums -> lane_cnt=0, act_valid=0, and the next word starts at lane 0.
